// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA raster timing generator.
// Holds the 800x600@60 default timing, a 640x480@60 alternative, the
// per-axis segment enum and a helper that classifies a counter value.
package vga_pkg;

  // 800x600@60, 40 MHz pixel clock (240 MHz / 6).
  localparam int unsigned Mode800ClkDiv   = 6;
  localparam int unsigned Mode800HVisible = 800;
  localparam int unsigned Mode800HFront   = 40;
  localparam int unsigned Mode800HSync    = 128;
  localparam int unsigned Mode800HBack    = 88;
  localparam int unsigned Mode800VVisible = 600;
  localparam int unsigned Mode800VFront   = 1;
  localparam int unsigned Mode800VSync    = 4;
  localparam int unsigned Mode800VBack    = 23;

  // 640x480@60, 25 MHz pixel clock (nominal 25.175 MHz).
  localparam int unsigned Mode640HVisible = 640;
  localparam int unsigned Mode640HFront   = 16;
  localparam int unsigned Mode640HSync    = 96;
  localparam int unsigned Mode640HBack    = 48;
  localparam int unsigned Mode640VVisible = 480;
  localparam int unsigned Mode640VFront   = 10;
  localparam int unsigned Mode640VSync    = 2;
  localparam int unsigned Mode640VBack    = 33;

  // Width of the rgb colour bars is 2**BarShift pixels.
  localparam int unsigned BarShift = 7;

  typedef enum logic [1:0] {
    SegVisible,
    SegFront,
    SegSync,
    SegBack
  } seg_e;

  // Segment that a raster position falls in, in visible/front/sync/back order.
  function automatic seg_e seg_of(input int unsigned pos, input int unsigned vis,
                                  input int unsigned front, input int unsigned sync);
    if (pos < vis) begin
      return SegVisible;
    end else if (pos < vis + front) begin
      return SegFront;
    end else if (pos < vis + front + sync) begin
      return SegSync;
    end
    return SegBack;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pixel pipeline.
// master: driven by the timing generator; slave: consumed downstream.
// Signals: pix_ce, hsync, vsync, de, x[H_W], y[V_W], frame_start and,
// with VGA_TEST_PATTERN_EN defined, rgb[3].
interface vga_timing_gen_if #(
  parameter int unsigned H_W = 11,
  parameter int unsigned V_W = 10
);
  logic           pix_ce;
  logic           hsync;
  logic           vsync;
  logic           de;
  logic [H_W-1:0] x;
  logic [V_W-1:0] y;
  logic           frame_start;
`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]     rgb;
`endif

  modport master (
    output pix_ce, hsync, vsync, de, x, y, frame_start
`ifdef VGA_TEST_PATTERN_EN
    , output rgb
`endif
  );

  modport slave (
    input pix_ce, hsync, vsync, de, x, y, frame_start
`ifdef VGA_TEST_PATTERN_EN
    , input rgb
`endif
  );
endinterface

// File: rtl/pixel_ce_div.sv
// Pixel clock-enable divider: tick counts 0..CLK_DIV-1 and wraps; ce is
// high while tick==0, so the first edge after reset is a pixel edge.
// Ports: clk, rst (async, active-high), ce (combinational from tick).
module pixel_ce_div #(
  parameter int unsigned CLK_DIV = 6
) (
  input  logic clk,
  input  logic rst,
  output logic ce
);
  localparam int unsigned TickW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [TickW-1:0] tick_q, tick_d;

  always_comb begin
    tick_d = tick_q + TickW'(1);
    if (tick_q == TickW'(CLK_DIV - 1)) begin
      tick_d = '0;
    end
  end

  assign ce = (tick_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. On each pixel edge the outputs
// register the decode of the current (h,v) and the counters then advance.
// Ports: clk, rst (async, active-high), vga (vga_timing_gen_if.master).
// Optional: VGA_TEST_PATTERN_EN adds registered rgb colour bars.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV    = Mode800ClkDiv,
  parameter int unsigned H_VISIBLE  = Mode800HVisible,
  parameter int unsigned H_FRONT    = Mode800HFront,
  parameter int unsigned H_SYNC     = Mode800HSync,
  parameter int unsigned H_BACK     = Mode800HBack,
  parameter int unsigned V_VISIBLE  = Mode800VVisible,
  parameter int unsigned V_FRONT    = Mode800VFront,
  parameter int unsigned V_SYNC     = Mode800VSync,
  parameter int unsigned V_BACK     = Mode800VBack,
  parameter bit          H_SYNC_POS = 1'b1,
  parameter bit          V_SYNC_POS = 1'b1,
  parameter int unsigned H_W        = 11,
  parameter int unsigned V_W        = 10
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);
  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  logic           ce;
  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;
  seg_e           h_seg, v_seg;
  logic           de_d, hsync_d, vsync_d, fs_d;

  logic           pix_ce_q, hsync_q, vsync_q, de_q, fs_q;
  logic [H_W-1:0] x_q;
  logic [V_W-1:0] y_q;

  pixel_ce_div #(
    .CLK_DIV(CLK_DIV)
  ) u_ce_div (
    .clk(clk),
    .rst(rst),
    .ce (ce)
  );

  always_comb begin
    h_seg = seg_of(32'(h_q), H_VISIBLE, H_FRONT, H_SYNC);
    v_seg = seg_of(32'(v_q), V_VISIBLE, V_FRONT, V_SYNC);
    de_d    = (h_seg == SegVisible) && (v_seg == SegVisible);
    // XOR with the inverted polarity turns "in sync segment" into the pin level.
    hsync_d = (h_seg == SegSync) ^ ~H_SYNC_POS;
    vsync_d = (v_seg == SegSync) ^ ~V_SYNC_POS;
    fs_d    = (h_q == '0) && (v_q == '0);

    h_d = h_q + H_W'(1);
    v_d = v_q;
    if (h_q == H_W'(HTotal - 1)) begin
      h_d = '0;
      v_d = (v_q == V_W'(VTotal - 1)) ? '0 : v_q + V_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q      <= '0;
      v_q      <= '0;
      pix_ce_q <= 1'b0;
      hsync_q  <= ~H_SYNC_POS;
      vsync_q  <= ~V_SYNC_POS;
      de_q     <= 1'b0;
      fs_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      pix_ce_q <= ce;
      if (ce) begin
        h_q     <= h_d;
        v_q     <= v_d;
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
        de_q    <= de_d;
        fs_q    <= fs_d;
        x_q     <= h_q;
        y_q     <= v_q;
      end
    end
  end

  assign vga.pix_ce      = pix_ce_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.de          = de_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.frame_start = fs_q;

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] rgb_q, rgb_d;

  always_comb begin
    // Go through 32 bits so narrow H_W builds still elaborate.
    rgb_d = de_d ? 3'(32'(h_q) >> BarShift) : 3'b000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q <= 3'b000;
    end else if (ce) begin
      rgb_q <= rgb_d;
    end
  end

  assign vga.rgb = rgb_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_def = 1'b1;
  logic rst_sm = 1'b1;
  logic rst_s1 = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_timing_gen_if #(.H_W(11), .V_W(10)) if_def ();
  vga_timing_gen_if #(.H_W(11), .V_W(10)) if_np ();
  vga_timing_gen_if #(.H_W(4), .V_W(3))   if_sm ();
  vga_timing_gen_if #(.H_W(4), .V_W(3))   if_s1 ();

  vga_timing_gen u_def (.clk(clk), .rst(rst_def), .vga(if_def));

  vga_timing_gen #(.H_SYNC_POS(1'b0)) u_np (.clk(clk), .rst(rst_def), .vga(if_np));

  vga_timing_gen #(
    .CLK_DIV(3), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .H_W(4), .V_W(3)
  ) u_sm (.clk(clk), .rst(rst_sm), .vga(if_sm));

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .H_W(4), .V_W(3)
  ) u_s1 (.clk(clk), .rst(rst_s1), .vga(if_s1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait (sampling on negedge) until the default DUT shows column target.
  task automatic wait_x(input int target);
    int n = 0;
    while (32'(if_def.x) != target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      failures++;
      $display("FAIL wait_x%0d: timed out, x=%0d", target, if_def.x);
    end
  endtask

  // Small-mode vectors: clk offset after first edge, x, y, de, hsync, vsync, fs, pix_ce.
  typedef struct {
    int off; int x; int y; bit de; bit hs; bit vs; bit fs; bit ce;
  } vec_t;

  vec_t sm_vec[$] = '{
    '{0,   0,  0, 1, 0, 0, 1, 1},
    '{1,   0,  0, 1, 0, 0, 1, 0},
    '{2,   0,  0, 1, 0, 0, 1, 0},
    '{3,   1,  0, 1, 0, 0, 0, 1},
    '{23,  7,  0, 1, 0, 0, 0, 0},
    '{24,  8,  0, 0, 0, 0, 0, 1},
    '{29,  9,  0, 0, 0, 0, 0, 0},
    '{30,  10, 0, 0, 1, 0, 0, 1},
    '{38,  12, 0, 0, 1, 0, 0, 0},
    '{39,  13, 0, 0, 0, 0, 0, 1},
    '{42,  0,  1, 1, 0, 0, 0, 1},
    '{72,  10, 1, 0, 1, 0, 0, 1},
    '{209, 13, 4, 0, 0, 0, 0, 0},
    '{210, 0,  5, 0, 0, 1, 0, 1},
    '{252, 0,  6, 0, 0, 1, 0, 1},
    '{293, 13, 6, 0, 0, 1, 0, 0},
    '{294, 0,  7, 0, 0, 0, 0, 1},
    '{335, 13, 7, 0, 0, 0, 0, 0},
    '{336, 0,  0, 1, 0, 0, 1, 1}
  };

  initial begin
    int c0;
    int cnt;
    int n;

    // Default mode: reset values.
    repeat (3) @(negedge clk);
    check("rst_x", 32'(if_def.x), 0);
    check("rst_y", 32'(if_def.y), 0);
    check("rst_de", 32'(if_def.de), 0);
    check("rst_fs", 32'(if_def.frame_start), 0);
    check("rst_pix_ce", 32'(if_def.pix_ce), 0);
    check("rst_hsync", 32'(if_def.hsync), 0);
    check("rst_vsync", 32'(if_def.vsync), 0);
    check("rst_hsync_neg", 32'(if_np.hsync), 1);
`ifdef VGA_TEST_PATTERN_EN
    check("rst_rgb", 32'(if_def.rgb), 0);
`endif

    rst_def = 1'b0;
    @(posedge clk);
    #1;
    c0 = cyc;
    check("first_x", 32'(if_def.x), 0);
    check("first_y", 32'(if_def.y), 0);
    check("first_de", 32'(if_def.de), 1);
    check("first_fs", 32'(if_def.frame_start), 1);
    check("first_pix_ce", 32'(if_def.pix_ce), 1);
    @(negedge clk);
    wait_x(1);
    check("x1_cyc", cyc - c0, 6);
    check("x1_fs", 32'(if_def.frame_start), 0);
`ifdef VGA_TEST_PATTERN_EN
    check("rgb_x1", 32'(if_def.rgb), 0);
    wait_x(127);
    check("rgb_x127", 32'(if_def.rgb), 0);
    wait_x(128);
    check("rgb_x128", 32'(if_def.rgb), 1);
    wait_x(799);
    check("rgb_x799", 32'(if_def.rgb), 6);
    wait_x(800);
    check("rgb_x800", 32'(if_def.rgb), 0);
`endif
    wait_x(799);
    check("x799_de", 32'(if_def.de), 1);
    wait_x(800);
    check("x800_de", 32'(if_def.de), 0);
    check("x800_cyc", cyc - c0, 4800);
    wait_x(839);
    check("np_x839", 32'(if_np.hsync), 1);
    check("pos_x839", 32'(if_def.hsync), 0);
    wait_x(840);
    check("np_x840", 32'(if_np.hsync), 0);
    check("pos_x840", 32'(if_def.hsync), 1);
    wait_x(967);
    check("np_x967", 32'(if_np.hsync), 0);
    wait_x(968);
    check("np_x968", 32'(if_np.hsync), 1);
    check("pos_x968", 32'(if_def.hsync), 0);
    wait_x(0);
    check("line_cyc", cyc - c0, 6336);
    check("line_y", 32'(if_def.y), 1);
    rst_def = 1'b1;

    // Small mode, CLK_DIV=3, one full frame of directed points.
    @(negedge clk);
    rst_sm = 1'b0;
    cnt = -1;
    foreach (sm_vec[i]) begin
      while (cnt < sm_vec[i].off) begin
        @(posedge clk);
        cnt++;
      end
      #1;
      check($sformatf("sm%0d_x", sm_vec[i].off), 32'(if_sm.x), 32'(sm_vec[i].x));
      check($sformatf("sm%0d_y", sm_vec[i].off), 32'(if_sm.y), 32'(sm_vec[i].y));
      check($sformatf("sm%0d_de", sm_vec[i].off), 32'(if_sm.de), 32'(sm_vec[i].de));
      check($sformatf("sm%0d_hs", sm_vec[i].off), 32'(if_sm.hsync), 32'(sm_vec[i].hs));
      check($sformatf("sm%0d_vs", sm_vec[i].off), 32'(if_sm.vsync), 32'(sm_vec[i].vs));
      check($sformatf("sm%0d_fs", sm_vec[i].off), 32'(if_sm.frame_start), 32'(sm_vec[i].fs));
      check($sformatf("sm%0d_ce", sm_vec[i].off), 32'(if_sm.pix_ce), 32'(sm_vec[i].ce));
    end

    // Reset mid-frame at (5,2), asserted between edges.
    n = 0;
    @(negedge clk);
    while (!(if_sm.x == 4'd5 && if_sm.y == 3'd2) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL midrst_wait: timed out at x=%0d y=%0d", if_sm.x, if_sm.y);
    end
    rst_sm = 1'b1;
    #1;
    check("midrst_x", 32'(if_sm.x), 0);
    check("midrst_y", 32'(if_sm.y), 0);
    check("midrst_de", 32'(if_sm.de), 0);
    check("midrst_pix_ce", 32'(if_sm.pix_ce), 0);
    @(negedge clk);
    rst_sm = 1'b0;
    @(posedge clk);
    #1;
    check("resume_x", 32'(if_sm.x), 0);
    check("resume_y", 32'(if_sm.y), 0);
    check("resume_fs", 32'(if_sm.frame_start), 1);
    repeat (3) @(posedge clk);
    #1;
    check("resume_x1", 32'(if_sm.x), 1);

    // CLK_DIV=1: every edge is a pixel edge.
    @(negedge clk);
    rst_s1 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("s1_%0d_ce", k), 32'(if_s1.pix_ce), 1);
      check($sformatf("s1_%0d_x", k), 32'(if_s1.x), 32'(k % 14));
    end
    check("s1_y", 32'(if_s1.y), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
